// File: rtl/booth_multiplier_r4.sv
// booth_multiplier_r4: sequential radix-4 Booth multiplier, ITER=WIDTH/2+1 cycles per op; ports clk, rst_n (async active-low), start, mc, mp, signed_mode -> prod, busy, done; BOOTH_ZERO_SKIP_EN finishes zero-operand ops in one cycle
module booth_multiplier_r4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy,
  output logic               done
);
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW = $clog2(ITER + 1);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_nx;
  logic signed [WIDTH+1:0] m;
  logic signed [WIDTH+3:0] hi, hi_sum, pp, m_x;
  logic [WIDTH+1:0] lo;
  logic q, zero, accept, last;
  logic [2:0] trip;
  logic [CW-1:0] cnt;
  function automatic logic [WIDTH+1:0] ext(input logic [WIDTH-1:0] x, input logic s);
    return s ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  endfunction
  always_comb begin
    trip = {lo[1:0], q};
    m_x = {{2{m[WIDTH+1]}}, m};
    pp = (trip == 3'b001 || trip == 3'b010) ? m_x :
         (trip == 3'b101 || trip == 3'b110) ? -m_x :
         (trip == 3'b011) ? m_x <<< 1 :
         (trip == 3'b100) ? -(m_x <<< 1) : '0;
    hi_sum = hi + pp;
`ifdef BOOTH_ZERO_SKIP_EN
    zero = (mc == '0) || (mp == '0);
`else
    zero = 1'b0;
`endif
    accept = (state == IDLE) && start;
    last = cnt == CW'(1);
    state_nx = (accept && !zero) ? CALC : (state == CALC && last) ? IDLE : state;
  end
  assign busy = state == CALC;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      done <= 1'b0;
      m <= '0;
      hi <= '0;
      lo <= '0;
      q <= 1'b0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept && zero) begin
        prod <= '0;
        done <= 1'b1;
      end else if (accept) begin
        m <= ext(mc, signed_mode);
        lo <= ext(mp, signed_mode);
        hi <= '0;
        q <= 1'b0;
        cnt <= CW'(ITER);
      end else if (state == CALC) begin
        hi <= hi_sum >>> 2;
        lo <= {hi_sum[1:0], lo[WIDTH+1:2]};
        q <= lo[1];
        cnt <= cnt - CW'(1);
        if (last) begin
          // Low 2*WIDTH bits of the final {hi_sum, lo} >>> 2.
          prod <= {hi_sum[WIDTH-1:0], lo[WIDTH+1:2]};
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_multiplier_r4.sv
// tb_booth_multiplier_r4: scoreboard bench for 8- and 16-bit booth_multiplier_r4 instances
module tb_booth_multiplier_r4;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start8 = 1'b0, sm8 = 1'b0, busy8, done8;
  logic [7:0] mc8 = '0, mp8 = '0;
  logic [15:0] prod8;
  logic start16 = 1'b0, sm16 = 1'b0, busy16, done16;
  logic [15:0] mc16 = '0, mp16 = '0;
  logic [31:0] prod16;
  logic [15:0] q8[$];
  logic [31:0] q16[$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  booth_multiplier_r4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mc(mc8), .mp(mp8),
    .signed_mode(sm8), .prod(prod8), .busy(busy8), .done(done8)
  );
  booth_multiplier_r4 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mc(mc16), .mp(mp16),
    .signed_mode(sm16), .prod(prod16), .busy(busy16), .done(done16)
  );
  task automatic wait_done8(input string name, input int exp_edges);
    int n = 0;
    logic [15:0] e;
    while (!done8 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (!done8 || n !== exp_edges) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges (done=%b), want %0d", name, n, done8, exp_edges);
    end
    vectors++;
    if (busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy in done cycle: got %b want 0", name, busy8);
    end
    e = q8.pop_front();
    vectors++;
    if (prod8 !== e) begin
      miscompares++;
      $display("FAIL %s prod: got %h want %h", name, prod8, e);
    end
  endtask
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] e);
    @(negedge clk);
    mc8 = a; mp8 = b; sm8 = s; start8 = 1'b1;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask
  function automatic int lat8(input logic [7:0] a, input logic [7:0] b);
    return (ZS && (a == 0 || b == 0)) ? 0 : 5;
  endfunction
  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] e);
    issue8(a, b, s, e);
    wait_done8(name, lat8(a, b));
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({prod8, busy8, done8} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset8: got prod=%h busy=%b done=%b want 0", prod8, busy8, done8);
    end
    vectors++;
    if ({prod16, busy16, done16} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset16: got prod=%h busy=%b done=%b want 0", prod16, busy16, done16);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_sweep;
    run8("u4x3", 8'd4, 8'd3, 1'b0, 16'h000C);
    run8("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run8("s255x255", 8'hFF, 8'hFF, 1'b1, 16'h0001);
  endtask
  task automatic test_signed_corners;
    run8("sm4xm3", 8'hFC, 8'hFD, 1'b1, 16'h000C);
    run8("sm128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
    run8("s127xm128", 8'h7F, 8'h80, 1'b1, 16'hC080);
    run8("sm128x1", 8'h80, 8'h01, 1'b1, 16'hFF80);
  endtask
  task automatic test_ignored;
    int extra = 0;
    issue8(8'd100, 8'd3, 1'b0, 16'h012C);
    @(posedge clk); #1;
    mc8 = 8'hFF; mp8 = 8'h11; sm8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8("ignored", 3);
    repeat (7) begin
      @(posedge clk); #1;
      if (done8 || busy8) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL ignored_start: got %0d active cycles after done, want 0", extra);
    end
  endtask
  task automatic test_back_to_back;
    issue8(8'd9, 8'd9, 1'b0, 16'h0051);
    wait_done8("b2b_first", 5);
    mc8 = 8'd7; mp8 = 8'd15; sm8 = 1'b0; start8 = 1'b1;
    q8.push_back(16'h0069);
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8("b2b_second", 5);
  endtask
  task automatic test_reset_mid;
    issue8(8'd200, 8'd201, 1'b0, 16'd40200);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({prod8, busy8, done8} !== 18'd0) begin
      miscompares++;
      $display("FAIL async_reset: got prod=%h busy=%b done=%b want 0", prod8, busy8, done8);
    end
    void'(q8.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    run8("after_reset", 8'd3, 8'd5, 1'b0, 16'h000F);
  endtask
  task automatic test_zero;
    run8("zero_mc", 8'd0, 8'h5A, 1'b0, 16'h0000);
    run8("zero_mp_signed", 8'h80, 8'd0, 1'b1, 16'h0000);
  endtask
  task automatic test_random16;
    logic [15:0] a, b;
    logic s;
    logic [31:0] e;
    logic signed [31:0] ps;
    int n;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0) begin a = 16'h8000; b = 16'h8000; end
      if (i == 1) begin a = 16'hFFFF; b = 16'hFFFF; end
      s = i[0];
      ps = $signed(a) * $signed(b);
      e = s ? ps : a * b;
      @(negedge clk);
      mc16 = a; mp16 = b; sm16 = s; start16 = 1'b1;
      q16.push_back(e);
      @(posedge clk); #1;
      start16 = 1'b0;
      n = 0;
      while (!done16 && n < 30) begin
        @(posedge clk); #1; n++;
      end
      vectors++;
      if (!done16 || n !== ((ZS && (a == 0 || b == 0)) ? 0 : 9)) begin
        miscompares++;
        $display("FAIL rand16 latency: got %0d edges (done=%b) want 9 (a=%h b=%h)", n, done16, a, b);
      end
      e = q16.pop_front();
      vectors++;
      if (prod16 !== e) begin
        miscompares++;
        $display("FAIL rand16 prod: got %h want %h (a=%h b=%h s=%b)", prod16, e, a, b, s);
      end
    end
  endtask
  initial begin
    test_reset();
    test_sweep();
    test_signed_corners();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    test_random16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
